sha1_msg_schedule: RTL

//  SHA-1 message-schedule engine for the hashing module. It takes one 512-bit block as
//  16 x 32-bit words, big-endian word order, W[0] first. It then streams W[0..79] one word
//  per handshake to the round datapath. The next 16 words are kept in a 16-deep sliding

---
 rtl/sha1_msg_schedule.sv | 107 ++++++++++
 1 files changed

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message-schedule engine.
// Loads one 512-bit block as 16 big-endian words. It then streams W[0..79]
// one word per output handshake. A 16-deep sliding window produces each
// expanded word as W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
module sha1_msg_schedule #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 80,
  parameter int WIN     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [6:0]        w_idx,
  output logic              w_last
);

  localparam int CW = $clog2(WIN);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     load_cnt;
  logic [6:0]        t;
  logic [WORD_W-1:0] win [WIN];
  logic              in_xfer;
  logic              out_xfer;
  logic [WORD_W-1:0] mix;
  logic [WORD_W-1:0] w_new;

  // Input is accepted only in LOAD and output is consumed only in EMIT.
  // Handshakes in the opposite state are therefore ignored.
  assign in_xfer  = (state == LOAD) && in_valid;
  assign out_xfer = (state == EMIT) && w_ready;

  // The window always holds W[t..t+15]. The taps at t+13, t+8, t+2 and t
  // therefore form W[t+16].
  assign mix   = win[WIN-3] ^ win[WIN-8] ^ win[WIN-14] ^ win[0];
  assign w_new = {mix[WORD_W-2:0], mix[WORD_W-1]};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state and output decode. All outputs come from registered state only,
  // so w_valid never depends combinationally on w_ready.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    w_valid   = 1'b0;
    w_data    = '0;
    w_idx     = t;
    w_last    = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_xfer && (load_cnt == CW'(WIN - 1))) state_nxt = EMIT;
      end
      EMIT: begin
        w_valid = 1'b1;
        w_data  = win[0];
        w_last  = (t == 7'(N_WORDS - 1));
        if (out_xfer && (t == 7'(N_WORDS - 1))) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Load counter and word index. Each wraps to 0 exactly when the FSM leaves its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      t        <= '0;
    end else begin
      if (in_xfer)
        load_cnt <= (load_cnt == CW'(WIN - 1)) ? '0 : load_cnt + CW'(1);
      if (out_xfer)
        t <= (t == 7'(N_WORDS - 1)) ? '0 : t + 7'd1;
    end
  end

  // Window: write-by-index while loading, then shift in W[t+16] on every output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the window is a register file, not a RAM. Resetting it clears any previous block's data.
      for (int k = 0; k < WIN; k++) win[k] <= '0;
    end else if (in_xfer) begin
      win[load_cnt] <= in_data;
    end else if (out_xfer) begin
      for (int k = 0; k < WIN - 1; k++) win[k] <= win[k+1];
      win[WIN-1] <= w_new;
    end
  end

endmodule
